// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: steps a/b through 00,01,10,11, captures gate y per vector and grades it.
// Optional macro TTS_FAIL_CNT_EN enables the saturating failed-run counter on o_fail_count.
`default_nettype none

module truth_table_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_sel_in,
  input  logic             i_gate_y,
  output logic             o_a_out,
  output logic             o_b_out,
  output logic [2:0]       o_sel_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_table_out,
  output logic             o_pass,
  output logic [7:0]       o_fail_count
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_vec, w_vec_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_a, w_a_nxt;
  logic             r_b, w_b_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [3:0]       r_table, w_table_nxt;
  logic             r_pass, w_pass_nxt;

  logic             w_capture;
  logic             w_last;
  logic [3:0]       w_table_cap;
  logic             w_run_pass;

  function automatic logic [3:0] f_expected(input logic [2:0] sel);
    case (sel)
      3'b000:  f_expected = 4'b1000;
      3'b001:  f_expected = 4'b1110;
      3'b010:  f_expected = 4'b0011;
      3'b011:  f_expected = 4'b0111;
      3'b100:  f_expected = 4'b0001;
      3'b101:  f_expected = 4'b0110;
      3'b110:  f_expected = 4'b1001;
      default: f_expected = 4'b0000;
    endcase
  endfunction

  assign w_capture = (r_state == S_RUN) && (r_cnt == C_CNT_LAST);
  assign w_last    = w_capture && (r_vec == 2'd3);

  // Table including this cycle's sample, so the grade sees the final vector.
  always_comb begin
    w_table_cap        = r_table;
    w_table_cap[r_vec] = i_gate_y;
  end

  assign w_run_pass = (w_table_cap == f_expected(r_sel));

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_table_nxt = r_table;
    w_pass_nxt  = r_pass;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_sel_nxt   = i_sel_in;
          w_table_nxt = 4'b0000;
          w_pass_nxt  = 1'b0;
          w_vec_nxt   = 2'd0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_a_nxt     = 1'b0;
          w_b_nxt     = 1'b0;
        end
      end
      S_RUN: begin
        w_busy_nxt = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (w_capture) begin
          w_table_nxt = w_table_cap;
          w_cnt_nxt   = '0;
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_a_nxt     = 1'b0;
            w_b_nxt     = 1'b0;
            w_pass_nxt  = w_run_pass;
          end else begin
            w_vec_nxt              = r_vec + 2'd1;
            {w_a_nxt, w_b_nxt}     = r_vec + 2'd1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= 2'd0;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_sel   <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= 4'b0000;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_table <= w_table_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

`ifdef TTS_FAIL_CNT_EN
  logic [7:0] r_fail_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_cnt <= 8'd0;
    end else if (w_last && !w_run_pass && (r_fail_cnt != 8'hFF)) begin
      r_fail_cnt <= r_fail_cnt + 8'd1;
    end
  end

  assign o_fail_count = r_fail_cnt;
`else
  assign o_fail_count = 8'd0;
`endif

  assign o_a_out     = r_a;
  assign o_b_out     = r_b;
  assign o_sel_out   = r_sel;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_table_out = r_table;
  assign o_pass      = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: table-driven bench for DWELL=4 and DWELL=1 instances with a gate model.
`default_nettype none

module tb_truth_table_sequencer;

`ifdef TTS_FAIL_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [2];
  logic [2:0] sel_s   [2];
  int         fault_s [2];

  logic [1:0] a_w, b_w, busy_w, done_w, pass_w, y_w;
  logic [2:0] selo_w [2];
  logic [3:0] tab_w  [2];
  logic [7:0] fc_w   [2];

  int n_cmp = 0;
  int n_err = 0;
  int exp_fc [2];

  always #5 clk = ~clk;

  function automatic logic gate(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'b000:  gate = a & b;
      3'b001:  gate = a | b;
      3'b010:  gate = ~a;
      3'b011:  gate = ~(a & b);
      3'b100:  gate = ~(a | b);
      3'b101:  gate = a ^ b;
      3'b110:  gate = ~(a ^ b);
      default: gate = 1'b0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (fault_s[i] == 1)      y_w[i] = 1'b1;
      else if (fault_s[i] == 2) y_w[i] = 1'b0;
      else                      y_w[i] = gate(selo_w[i], a_w[i], b_w[i]);
    end
  end

  truth_table_sequencer #(.DWELL_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start_s[0]), .i_sel_in(sel_s[0]), .i_gate_y(y_w[0]),
    .o_a_out(a_w[0]), .o_b_out(b_w[0]), .o_sel_out(selo_w[0]), .o_busy(busy_w[0]),
    .o_done(done_w[0]), .o_table_out(tab_w[0]), .o_pass(pass_w[0]), .o_fail_count(fc_w[0])
  );

  truth_table_sequencer #(.DWELL_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start_s[1]), .i_sel_in(sel_s[1]), .i_gate_y(y_w[1]),
    .o_a_out(a_w[1]), .o_b_out(b_w[1]), .o_sel_out(selo_w[1]), .o_busy(busy_w[1]),
    .o_done(done_w[1]), .o_table_out(tab_w[1]), .o_pass(pass_w[1]), .o_fail_count(fc_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse start, walk the run cycle by cycle, return done latency and per-cycle busy/a/b errors.
  task automatic run(input int d, input logic [2:0] sel, input int flt, output int lat, output int errs);
    int dw;
    dw = (d == 0) ? 4 : 1;
    fault_s[d] = flt;
    sel_s[d]   = sel;
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    lat  = 0;
    errs = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (done_w[d]) begin
        lat = k;
        if (busy_w[d] || a_w[d] || b_w[d]) errs++;
      end else if (!busy_w[d] || int'({a_w[d], b_w[d]}) != (k - 1) / dw) begin
        errs++;
      end
      @(posedge clk); #1;
    end
    if (done_w[d]) errs++;
  endtask

  task automatic run_check(input int d, input logic [2:0] sel, input int flt,
                           input logic [3:0] etab, input logic epass, input string name);
    int lat, errs;
    run(d, sel, flt, lat, errs);
    if (!epass && FC_EN && exp_fc[d] < 255) exp_fc[d]++;
    check({name, " latency"}, lat, (d == 0) ? 17 : 5);
    check({name, " busy/ab walk"}, errs, 0);
    check({name, " table"}, {28'd0, tab_w[d]}, {28'd0, etab});
    check({name, " pass"}, {31'd0, pass_w[d]}, {31'd0, epass});
    check({name, " sel_out"}, {29'd0, selo_w[d]}, {29'd0, sel});
    check({name, " fail_count"}, {24'd0, fc_w[d]}, exp_fc[d]);
  endtask

  typedef struct {
    logic [2:0] sel;
    int         fault;
    logic [3:0] exp_tab;
    logic       exp_pass;
  } vec_t;

  vec_t tv [11];

  initial begin
    int lat, errs, dones, first;

    tv[0]  = '{3'b000, 0, 4'b1000, 1'b1};
    tv[1]  = '{3'b001, 0, 4'b1110, 1'b1};
    tv[2]  = '{3'b010, 0, 4'b0011, 1'b1};
    tv[3]  = '{3'b011, 0, 4'b0111, 1'b1};
    tv[4]  = '{3'b100, 0, 4'b0001, 1'b1};
    tv[5]  = '{3'b101, 0, 4'b0110, 1'b1};
    tv[6]  = '{3'b110, 0, 4'b1001, 1'b1};
    tv[7]  = '{3'b111, 0, 4'b0000, 1'b1};
    tv[8]  = '{3'b000, 1, 4'b1111, 1'b0};
    tv[9]  = '{3'b111, 2, 4'b0000, 1'b1};
    tv[10] = '{3'b110, 1, 4'b1111, 1'b0};

    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      sel_s[i]   = 3'b000;
      fault_s[i] = 0;
      exp_fc[i]  = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {a_w[0], b_w[0], selo_w[0], busy_w[0], done_w[0], tab_w[0], pass_w[0], fc_w[0]}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_check(0, tv[i].sel, tv[i].fault, tv[i].exp_tab, tv[i].exp_pass, $sformatf("vec%0d", i));

    // Repeated failing runs drive the counter into saturation.
    repeat (FC_EN ? 256 : 2) begin
      run(0, 3'b000, 1, lat, errs);
      if (FC_EN && exp_fc[0] < 255) exp_fc[0]++;
    end
    check("fail_count saturation", {24'd0, fc_w[0]}, exp_fc[0]);
    check("fail run pass low", {31'd0, pass_w[0]}, 0);

    // start re-pulse and sel change mid-run are ignored.
    fault_s[0] = 0;
    sel_s[0]   = 3'b001;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    dones = 0;
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 5) start_s[0] = 1'b1;
      if (k == 6) begin
        start_s[0] = 1'b0;
        sel_s[0]   = 3'b011;
      end
      if (done_w[0]) begin
        dones++;
        if (first == 0) first = k;
      end
      @(posedge clk); #1;
    end
    check("ignore done count", dones, 1);
    check("ignore done cycle", first, 17);
    check("ignore sel_out", {29'd0, selo_w[0]}, 3'b001);
    check("ignore table", {28'd0, tab_w[0]}, 4'b1110);
    check("ignore pass", {31'd0, pass_w[0]}, 1);

    // Asynchronous reset mid-run.
    sel_s[0]   = 3'b000;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrun reset outputs",
          {a_w[0], b_w[0], selo_w[0], busy_w[0], done_w[0], tab_w[0], pass_w[0], fc_w[0]}, 0);
    dones = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_w[0]) dones++;
      @(posedge clk); #1;
    end
    check("midrun reset no done", dones, 0);
    run_check(0, 3'b101, 0, 4'b0110, 1'b1, "post-reset xor");

    // Single-cycle dwell instance.
    run_check(1, 3'b111, 0, 4'b0000, 1'b1, "dwell1 const0");
    run_check(1, 3'b000, 0, 4'b1000, 1'b1, "dwell1 and");
    run_check(1, 3'b100, 1, 4'b1111, 1'b0, "dwell1 stuck nor");

    // start held high: each run restarts from the IDLE cycle after DONE.
    sel_s[0]   = 3'b001;
    start_s[0] = 1'b1;
    dones = 0;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_w[0]) begin
        dones++;
        if (first == 0) first = k;
      end
    end
    start_s[0] = 1'b0;
    check("held start done count", dones, 2);
    check("held start first done", first, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Automatic truth-table stepper for the trainer-kit gate selector. On `start` it latches a gate select and drives `a` and `b` through the vectors 00, 01, 10, 11 into the combinational gate unit. It samples the gate's `y` after a programmable settle time for each vector and assembles a 4-bit truth table. It then compares that table against the built-in expected table for the selected gate and reports pass/fail. It sits directly upstream of the gate unit, driving its `a`, `b` and `sel`, and consumes its `y`.

Parameters:
- DWELL_CYCLES, 4: clock cycles each vector is held before `y` is sampled. Legal range is 1..255.
- CNT_W, 8: width of the dwell counter. Must satisfy DWELL_CYCLES <= 2^CNT_W - 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- sel_in  in  3  gate select to test (000 AND, 001 OR, 010 NOT-a, 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 const-0).
- gate_y  in  1  output of the gate unit under test.
- a_out  out  1  drives the gate unit's `a`.
- b_out  out  1  drives the gate unit's `b`.
- sel_out  out  3  drives the gate unit's `sel`; holds the latched value.
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse when a run completes.
- table_out  out  4  captured truth table; bit i = `y` for vector i, where i = {a,b}.
- pass  out  1  1 when table_out equals the expected table for sel_out; valid from `done` onward.
- fail_count  out  8  see Optional Feature.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: every output is 0, state is IDLE, and the internal vector and dwell counters are 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - sel_out <= sel_in.
  - table_out <= 0, pass <= 0.
  - vec <= 0, cnt <= 0.
  - go to RUN.
- IDLE, start=0: all outputs hold their values.
- RUN:
  - busy=1; {a_out,b_out} = vec (registered outputs).
  - cnt increments every cycle.
  - When cnt == DWELL_CYCLES-1: table_out[vec] <= gate_y and cnt <= 0.
  - If vec == 3 at that point, go to DONE; otherwise vec <= vec+1.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - pass <= (table_out == expected(sel_out)), computed with the final capture already included.
  - a_out and b_out return to 0.
  - go to IDLE.
- Expected tables, written as bits[3:0] = vectors 11,10,01,00:
  - AND 1000, OR 1110, NOT-a 0011, NAND 0111.
  - NOR 0001, XOR 0110, XNOR 1001, 111 → 0000.
- Latency:
  - RUN lasts exactly 4×DWELL_CYCLES cycles.
  - `done` is high in the cycle immediately after the last RUN cycle. With the default DWELL=4, that is the 17th cycle after the edge that sampled `start`.
- Boundary conditions:
  - `start` asserted in RUN or DONE is ignored; there is no queuing.
  - Changes to `sel_in` during a run are ignored; sel_out stays latched.
  - DWELL_CYCLES=1: each vector is held one cycle and `gate_y` is sampled in that same cycle. This is legal only because the gate unit is purely combinational.
  - table_out, pass and sel_out hold after DONE until the next accepted `start`.
  - Reset asserted mid-run: immediate return to reset values, with no `done` pulse.
  - `start` held high continuously: a new run begins in the IDLE cycle following each DONE.

Optional Feature:
Macro TTS_FAIL_CNT_EN.
- When defined: fail_count increments by 1 in each DONE cycle where the computed pass is 0. It saturates at 255 and is cleared only by `rst`.
- When not defined: fail_count is tied to 0, no counter logic is synthesised, and all other behaviour is identical.

Test Plan:
1. DWELL=4, ideal gate model, sel_in=000, `start` pulse → a/b step 00,01,10,11, four cycles each; table_out=1000, pass=1; `done` high on cycle 17, busy high for cycles 1–16.
2. sel_in=101 (XOR) and sel_in=010 (NOT-a) runs → table_out=0110 and 0011 respectively, pass=1 for both; fail_count stays 0.
3. Gate model stuck-at-1, sel_in=000 → table_out=1111, pass=0; with TTS_FAIL_CNT_EN, fail_count=1. 256 further failing runs → fail_count saturates at 255.
4. `start` re-pulsed at cycle 5 and sel_in switched to 011 at cycle 6 during a sel=001 run → run unaffected, sel_out=001, table_out=1110, exactly one `done` pulse.
5. `rst` asserted at cycle 9 of a run → all outputs read 0 immediately, no `done` pulse. A fresh `start` after reset release completes normally.
6. DWELL=1, sel_in=111 → RUN lasts 4 cycles, `done` on cycle 5, table_out=0000, pass=1.
